// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller: operation codes,
// FSM state encoding and small decode helpers.
package mdu_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        MDU_MULTop  = 3'd0,
        MDU_MULTUop = 3'd1,
        MDU_DIVop   = 3'd2,
        MDU_DIVUop  = 3'd3,
        MDU_MTHIop  = 3'd4,
        MDU_MTLOop  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == MDU_MULTop) || (op == MDU_MULTUop);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIVop) || (op == MDU_DIVUop);
    endfunction

    function automatic logic is_long_op(input logic [2:0] op);
        return is_mul_op(op) || is_div_op(op);
    endfunction

    function automatic int unsigned max_u(input int unsigned x, input int unsigned y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational result generator: latched op/A/B -> {hi_nx, lo_nx} plus the
// divide-by-zero hold flag that suppresses the HI/LO write at commit.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi_nx,
    output logic [XLEN-1:0] lo_nx,
    output logic            hold
);

    logic signed [2*XLEN-1:0] a_s64;
    logic signed [2*XLEN-1:0] b_s64;
    logic signed [2*XLEN-1:0] sprod;
    logic        [2*XLEN-1:0] uprod;
    logic                     div_zero;
    logic                     div_ovf;
    logic        [XLEN-1:0]   s_div_b;
    logic        [XLEN-1:0]   u_div_b;
    logic signed [XLEN-1:0]   squot;
    logic signed [XLEN-1:0]   srem;
    logic        [XLEN-1:0]   uquot;
    logic        [XLEN-1:0]   urem;

    assign a_s64 = {{XLEN{a[XLEN-1]}}, a};
    assign b_s64 = {{XLEN{b[XLEN-1]}}, b};
    assign sprod = a_s64 * b_s64;
    assign uprod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};

    assign div_zero = (b == '0);
    assign div_ovf  = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

    // Dividing by 1 instead of -1 on overflow yields exactly LO=A=0x80000000, HI=0.
    assign s_div_b = (div_zero || div_ovf) ? XLEN'(1) : b;
    assign u_div_b = div_zero ? XLEN'(1) : b;

    assign squot = $signed(a) / $signed(s_div_b);
    assign srem  = $signed(a) % $signed(s_div_b);
    assign uquot = a / u_div_b;
    assign urem  = a % u_div_b;

    always_comb begin
        hi_nx = '0;
        lo_nx = '0;
        hold  = is_div_op(op) && div_zero;
        case (op)
            MDU_MULTop:  {hi_nx, lo_nx} = sprod;
            MDU_MULTUop: {hi_nx, lo_nx} = uprod;
            MDU_DIVop: begin
                lo_nx = squot;
                hi_nx = srem;
            end
            MDU_DIVUop: begin
                lo_nx = uquot;
                hi_nx = urem;
            end
            default: begin
                hi_nx = '0;
                lo_nx = '0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning HI/LO with a fixed-latency busy
// counter. Optional abort support is enabled by defining MDU_FLUSH_EN.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned CNT_W = $clog2(max_u(MULT_CYCLES, DIV_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

    mdu_state_e       state;
    mdu_state_e       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;

    logic             kill;
    logic             accept;
    logic             launch;
    logic             commit;

    logic [2:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      hi_nx;
    logic [31:0]      lo_nx;
    logic             hold;

`ifdef MDU_FLUSH_EN
    assign kill = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign kill = 1'b0;
`endif

    // An accepted start in IDLE either writes HI/LO directly or launches a long op.
    assign accept = start && (state == MDU_IDLE) && !kill;
    assign launch = accept && is_long_op(mdop);
    assign commit = (state == MDU_RUN) && (cnt == CNT_LAST) && !kill;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= MDU_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (kill) begin
            state_nx = MDU_IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (launch) begin
                        state_nx = MDU_RUN;
                        cnt_nx   = is_div_op(mdop) ? DIV_LOAD : MULT_LOAD;
                    end
                end
                MDU_RUN: begin
                    if (cnt == CNT_LAST) begin
                        state_nx = MDU_IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt - CNT_LAST;
                    end
                end
                default: begin
                    state_nx = MDU_IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy = (state == MDU_RUN);
    end

    mdu_arith u_arith (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .hi_nx (hi_nx),
        .lo_nx (lo_nx),
        .hold  (hold)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            HI   <= '0;
            LO   <= '0;
            op_q <= MDU_MULTop;
            a_q  <= '0;
            b_q  <= '0;
        end else begin
            if (launch) begin
                op_q <= mdop;
                a_q  <= A;
                b_q  <= B;
            end
            if (commit) begin
                if (!hold) begin
                    HI <= hi_nx;
                    LO <= lo_nx;
                end
            end else if (accept && (mdop == MDU_MTHIop)) begin
                HI <= A;
            end else if (accept && (mdop == MDU_MTLOop)) begin
                LO <= A;
            end
        end
    end

    start_while_busy: assert property (@(posedge clk) disable iff (!reset) !(start && busy));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: a driver issues ops and queues timed expectations
// from a plain-arithmetic model; a monitor compares them at each falling clock edge.
module tb_mdu_ctrl;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  mdop = '0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdop  (mdop),
        .A     (a_in),
        .B     (b_in),
        .flush (flush),
        .busy  (busy),
        .HI    (hi),
        .LO    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    string       tag_q[$];
    int unsigned edges  = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    always @(posedge clk) edges <= edges + 1;

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due == edges) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (busy !== e.busy || hi !== e.hi || lo !== e.lo) begin
                errors++;
                $display("FAIL %s @edge %0d: busy=%0b HI=%h LO=%h, required busy=%0b HI=%h LO=%h",
                         t, edges, busy, hi, lo, e.busy, e.hi, e.lo);
            end
        end
    end

    // Reference model: architectural effect of one accepted op on HI/LO.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, qm, q, r;
        case (op)
            OP_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                ref_hi = p[63:32];
                ref_lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                ref_hi = p[63:32];
                ref_lo = p[31:0];
            end
            OP_DIV: if (b != 0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                qm = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
                q  = ((sa < 0) != (sb < 0)) ? -qm : qm;
                r  = sa - q * sb;
                ref_lo = q[31:0];
                ref_hi = r[31:0];
            end
            OP_DIVU: if (b != 0) begin
                ref_lo = a / b;
                ref_hi = a % b;
            end
            OP_MTHI: ref_hi = a;
            OP_MTLO: ref_lo = a;
            default: ;
        endcase
    endfunction

    task automatic expect_at(input int unsigned due, input logic b, input string tag);
        exp_t e;
        e.due  = due;
        e.busy = b;
        e.hi   = ref_hi;
        e.lo   = ref_lo;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic wait_idle(input string tag);
        int unsigned t = 0;
        while (busy && t < 40) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s-idle: busy=%0b, required 0 within 40 cycles", tag, busy);
        end
    endtask

    // Long op issued at the next edge k; flush_at=j raises flush for edge k+j.
    task automatic run_long(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int unsigned flush_at, input string tag);
        int unsigned k, n;
        bit          flushing;
        flushing = 1'b0;
`ifdef MDU_FLUSH_EN
        flushing = (flush_at != 0);
`endif
        n = (op == OP_DIV || op == OP_DIVU) ? DIV_N : MULT_N;
        k = edges + 1;
        start = 1'b1; mdop = op; a_in = a; b_in = b; flush = 1'b0;
        if (flushing) begin
            if (flush_at >= 2) expect_at(k + flush_at - 1, 1'b1, {tag, "-run"});
            expect_at(k + flush_at, 1'b0, {tag, "-flushed"});
        end else begin
            if (n >= 2) expect_at(k + n - 1, 1'b1, {tag, "-run"});
            model(op, a, b);
            expect_at(k + n, 1'b0, {tag, "-commit"});
        end
        @(negedge clk);
        start = 1'b0;
        for (int unsigned j = 1; j <= n; j++) begin
            flush = (j == flush_at);
            @(negedge clk);
        end
        flush = 1'b0;
        wait_idle(tag);
    endtask

    task automatic run_imm(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic fl, input string tag);
        bit dropped;
        dropped = 1'b0;
`ifdef MDU_FLUSH_EN
        dropped = fl;
`endif
        start = 1'b1; mdop = op; a_in = a; b_in = b; flush = fl;
        if (!dropped) model(op, a, b);
        expect_at(edges + 1, 1'b0, tag);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int unsigned k;
        @(negedge clk);
        expect_at(edges + 1, 1'b0, "reset-state");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_long(OP_MULT,  32'hFFFF_FFFE, 32'd3, 0, "mult-neg");
        run_long(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 0, "multu");
        run_long(OP_DIV,   32'hFFFF_FFF9, 32'd2, 0, "div-neg");
        run_long(OP_DIVU,  32'd7,         32'd2, 0, "divu");
        run_imm (OP_MTHI,  32'h11, 32'h0, 1'b0, "mthi");
        run_imm (OP_MTLO,  32'h22, 32'h0, 1'b0, "mtlo");
        run_long(OP_DIV,   32'd1234,      32'd0, 0, "div-zero");
        run_long(OP_DIVU,  32'hDEAD_BEEF, 32'd0, 0, "divu-zero");
        run_long(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, "div-ovf");
        run_imm (3'd6,     32'h1234_5678, 32'h0, 1'b0, "invalid-op");

        // Reset lands three edges into a MULT; the pending product must be discarded.
        k = edges + 1;
        start = 1'b1; mdop = OP_MULT; a_in = 32'd9; b_in = 32'd9;
        expect_at(k + 2, 1'b1, "reset-prebusy");
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ref_hi = '0;
        ref_lo = '0;
        expect_at(k + 3, 1'b0, "reset-abort");
        @(negedge clk);
        reset = 1'b1;
        run_imm(OP_MTLO, 32'h5, 32'h0, 1'b0, "reset-mtlo");
        expect_at(k + 5, 1'b0, "reset-no-commit");
        repeat (2) @(negedge clk);

        run_imm (OP_MTHI, 32'hAAAA_0001, 32'h0, 1'b0, "pre-flush-hi");
        run_long(OP_DIV,  32'd100, 32'd7, 9, "flush9");
        run_long(OP_MULT, 32'd6,   32'd7, MULT_N, "flush-at-commit");
        run_imm (OP_MTHI, 32'hDEAD_0000, 32'h0, 1'b1, "flush-mthi");

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            if (op <= OP_DIVU) run_long(op, a, b, 0, $sformatf("rand%0d", i));
            else               run_imm(op, a, b, 1'b0, $sformatf("rand%0d", i));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard-drain: %0d pending entries, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
